// File: rtl/logic_axi4_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : logic_axi4_stream_packer
// Description : AXI4-Stream byte packer. Drops null bytes and emits dense,
//               low-aligned beats, packing across beats of one tid/tdest flow.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_axi4_stream_packer #(
    parameter int TDATA_BYTES = 4,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int FLUSH_ON_ID = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       rx_tvalid,
    output logic                       rx_tready,
    input  logic [8*TDATA_BYTES-1:0]   rx_tdata,
    input  logic [TDATA_BYTES-1:0]     rx_tkeep,
    input  logic                       rx_tlast,
    input  logic [TID_WIDTH-1:0]       rx_tid,
    input  logic [TDEST_WIDTH-1:0]     rx_tdest,
    input  logic [TUSER_WIDTH-1:0]     rx_tuser,
    output logic                       tx_tvalid,
    input  logic                       tx_tready,
    output logic [8*TDATA_BYTES-1:0]   tx_tdata,
    output logic [TDATA_BYTES-1:0]     tx_tkeep,
    output logic                       tx_tlast,
    output logic [TID_WIDTH-1:0]       tx_tid,
    output logic [TDEST_WIDTH-1:0]     tx_tdest,
    output logic [TUSER_WIDTH-1:0]     tx_tuser
);

    localparam int c_N       = TDATA_BYTES;
    localparam int c_DW      = 8 * c_N;
    localparam int c_CW      = $clog2(c_N + 1);
    localparam int c_TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [c_CW:0]   c_N_EXT  = (c_CW + 1)'(c_N);
    localparam logic [c_CW-1:0] c_N_CNT  = c_CW'(c_N);
    localparam logic [c_TW-1:0] c_TO_HIT = c_TW'(c_TO_LAST);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    function automatic logic [c_N-1:0] f_therm(input logic [c_CW:0] cnt);
        logic [c_N-1:0] t;
        for (int i = 0; i < c_N; i++) begin
            t[i] = (i < int'(cnt));
        end
        return t;
    endfunction

    logic [0:0]             r_state,    w_state_nxt;
    logic [c_CW-1:0]        r_cnt,      w_cnt_nxt;
    logic [c_DW-1:0]        r_res,      w_res_nxt;
    logic [TID_WIDTH-1:0]   r_res_id,   w_res_id_nxt;
    logic [TDEST_WIDTH-1:0] r_res_dest, w_res_dest_nxt;
    logic [TUSER_WIDTH-1:0] r_res_user, w_res_user_nxt;
    logic [c_TW-1:0]        r_to_cnt,   w_to_cnt_nxt;

    logic                   r_tx_valid, w_tx_valid_nxt;
    logic [c_DW-1:0]        r_tx_data,  w_tx_data_nxt;
    logic [c_N-1:0]         r_tx_keep,  w_tx_keep_nxt;
    logic                   r_tx_last,  w_tx_last_nxt;
    logic [TID_WIDTH-1:0]   r_tx_id,    w_tx_id_nxt;
    logic [TDEST_WIDTH-1:0] r_tx_dest,  w_tx_dest_nxt;
    logic [TUSER_WIDTH-1:0] r_tx_user,  w_tx_user_nxt;

    logic [c_DW-1:0]        w_pk;
    logic [c_CW-1:0]        w_k;
    logic [c_N-1:0]         w_res_keep;
    logic [c_DW-1:0]        w_res_mask;
    logic [c_DW-1:0]        w_res_data;
    logic [2*c_DW-1:0]      w_cat;
    logic [c_CW:0]          w_sum;
    logic [c_CW-1:0]        w_rem;
    logic                   w_last;
    logic                   w_free;
    logic                   w_run;
    logic                   w_id_diff;
    logic                   w_id_flush;
    logic                   w_to_hit;
    logic                   w_acc;

    // Compact the kept lanes of the incoming beat into its low bytes.
    always_comb begin
        int pos;
        w_pk = '0;
        pos  = 0;
        for (int i = 0; i < c_N; i++) begin
            if (rx_tkeep[i]) begin
                w_pk[8*pos +: 8] = rx_tdata[8*i +: 8];
                pos = pos + 1;
            end
        end
        w_k = c_CW'(pos);
    end

    always_comb begin
        w_res_keep = f_therm({1'b0, r_cnt});
        w_res_mask = '0;
        for (int i = 0; i < c_N; i++) begin
            w_res_mask[8*i +: 8] = {8{w_res_keep[i]}};
        end
    end

    // Residue bytes above C are stale after a flush, hence the mask.
    assign w_res_data = r_res & w_res_mask;
    assign w_cat      = {{c_DW{1'b0}}, w_res_data} | ({{c_DW{1'b0}}, w_pk} << {r_cnt, 3'b000});
    assign w_sum      = {1'b0, r_cnt} + {1'b0, w_k};
    assign w_rem      = w_sum[c_CW-1:0] - c_N_CNT;

    assign w_last     = (USE_TLAST != 0) && rx_tlast;
    assign w_free     = !r_tx_valid || tx_tready;
    assign w_run      = (r_state == c_ST_RUN);
    assign w_id_diff  = (rx_tid != r_res_id) || (rx_tdest != r_res_dest);
    assign w_id_flush = (FLUSH_ON_ID != 0) && w_run && rx_tvalid && (r_cnt != '0) && w_id_diff;
    assign w_to_hit   = (TIMEOUT > 0) && w_run && !rx_tvalid && (r_cnt != '0) && (r_to_cnt == c_TO_HIT);

    assign rx_tready  = !areset && w_free && w_run && !w_id_flush;
    assign w_acc      = rx_tvalid && rx_tready;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_res_nxt      = r_res;
        w_res_id_nxt   = r_res_id;
        w_res_dest_nxt = r_res_dest;
        w_res_user_nxt = r_res_user;
        w_to_cnt_nxt   = r_to_cnt;
        w_tx_valid_nxt = r_tx_valid && !tx_tready;
        w_tx_data_nxt  = r_tx_data;
        w_tx_keep_nxt  = r_tx_keep;
        w_tx_last_nxt  = r_tx_last;
        w_tx_id_nxt    = r_tx_id;
        w_tx_dest_nxt  = r_tx_dest;
        w_tx_user_nxt  = r_tx_user;

        // Idle counter saturates at the hit value until the output frees up.
        if (w_run && !rx_tvalid && (r_cnt != '0)) begin
            if (r_to_cnt != c_TO_HIT) begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
        end else begin
            w_to_cnt_nxt = '0;
        end

        if (w_free) begin
            if (!w_run) begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_res_data;
                w_tx_keep_nxt  = w_res_keep;
                w_tx_last_nxt  = 1'b1;
                w_tx_id_nxt    = r_res_id;
                w_tx_dest_nxt  = r_res_dest;
                w_tx_user_nxt  = r_res_user;
                w_cnt_nxt      = '0;
                w_state_nxt    = c_ST_RUN;
            end else if (w_id_flush || w_to_hit) begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_res_data;
                w_tx_keep_nxt  = w_res_keep;
                w_tx_last_nxt  = 1'b0;
                w_tx_id_nxt    = r_res_id;
                w_tx_dest_nxt  = r_res_dest;
                w_tx_user_nxt  = r_res_user;
                w_cnt_nxt      = '0;
                w_to_cnt_nxt   = '0;
            end else if (w_acc) begin
                w_res_id_nxt   = rx_tid;
                w_res_dest_nxt = rx_tdest;
                w_res_user_nxt = rx_tuser;
                w_tx_id_nxt    = rx_tid;
                w_tx_dest_nxt  = rx_tdest;
                w_tx_user_nxt  = rx_tuser;
                if (w_sum >= c_N_EXT) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = w_cat[c_DW-1:0];
                    w_tx_keep_nxt  = '1;
                    w_tx_last_nxt  = w_last && (w_sum == c_N_EXT);
                    w_res_nxt      = w_cat[2*c_DW-1:c_DW];
                    w_cnt_nxt      = w_rem;
                    if (w_last && (w_sum != c_N_EXT)) begin
                        w_state_nxt = c_ST_FLUSH;
                    end
                end else if (w_last) begin
                    // Covers both the short tail and the null tlast beat.
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = w_cat[c_DW-1:0];
                    w_tx_keep_nxt  = f_therm(w_sum);
                    w_tx_last_nxt  = 1'b1;
                    w_cnt_nxt      = '0;
                end else begin
                    w_res_nxt      = w_cat[c_DW-1:0];
                    w_cnt_nxt      = w_sum[c_CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= c_ST_RUN;
            r_cnt      <= '0;
            r_res      <= '0;
            r_res_id   <= '0;
            r_res_dest <= '0;
            r_res_user <= '0;
            r_to_cnt   <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_keep  <= '0;
            r_tx_last  <= 1'b0;
            r_tx_id    <= '0;
            r_tx_dest  <= '0;
            r_tx_user  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_res      <= w_res_nxt;
            r_res_id   <= w_res_id_nxt;
            r_res_dest <= w_res_dest_nxt;
            r_res_user <= w_res_user_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_keep  <= w_tx_keep_nxt;
            r_tx_last  <= w_tx_last_nxt;
            r_tx_id    <= w_tx_id_nxt;
            r_tx_dest  <= w_tx_dest_nxt;
            r_tx_user  <= w_tx_user_nxt;
        end
    end

    assign tx_tvalid = r_tx_valid;
    assign tx_tdata  = r_tx_data;
    assign tx_tkeep  = r_tx_keep;
    assign tx_tlast  = r_tx_last;
    assign tx_tid    = r_tx_id;
    assign tx_tdest  = r_tx_dest;
    assign tx_tuser  = r_tx_user;

endmodule
`default_nettype wire

// File: tb/tb_logic_axi4_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_axi4_stream_packer
// Description : Scoreboard bench for the AXI4-Stream byte packer (N=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_axi4_stream_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [31:0] rx_tdata;
    logic [3:0]  rx_tkeep;
    logic        rx_tlast;
    logic [2:0]  rx_tid;
    logic [0:0]  rx_tdest;
    logic [0:0]  rx_tuser;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tkeep;
    logic        tx_tlast;
    logic [2:0]  tx_tid;
    logic [0:0]  tx_tdest;
    logic [0:0]  tx_tuser;

    logic_axi4_stream_packer #(
        .TDATA_BYTES (4),
        .TDEST_WIDTH (1),
        .TUSER_WIDTH (1),
        .TID_WIDTH   (3),
        .USE_TLAST   (1),
        .FLUSH_ON_ID (1),
        .TIMEOUT     (8)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .rx_tdata  (rx_tdata),
        .rx_tkeep  (rx_tkeep),
        .rx_tlast  (rx_tlast),
        .rx_tid    (rx_tid),
        .rx_tdest  (rx_tdest),
        .rx_tuser  (rx_tuser),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tkeep  (tx_tkeep),
        .tx_tlast  (tx_tlast),
        .tx_tid    (tx_tid),
        .tx_tdest  (tx_tdest),
        .tx_tuser  (tx_tuser)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [2:0]  id;
        logic        dest;
        logic        user;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] m_res[$];
    logic [2:0] m_id   = 3'd0;
    logic       m_dest = 1'b0;
    logic       m_user = 1'b0;
    int         n_cmp  = 0;
    int         n_err  = 0;
    logic       rand_ready = 1'b0;
    logic       in_reset   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic emit(input int n, input logic last, input logic [2:0] id,
                        input logic dest, input logic user);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        for (int i = 0; i < n; i++) begin
            b.data[8*i +: 8] = m_res.pop_front();
            b.keep[i]        = 1'b1;
        end
        b.last = last;
        b.id   = id;
        b.dest = dest;
        b.user = user;
        exp_q.push_back(b);
    endtask

    task automatic model_flush();
        emit(m_res.size(), 1'b0, m_id, m_dest, m_user);
    endtask

    // Reference behaviour of one accepted rx beat.
    task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input logic l,
                                input logic [2:0] id, input logic dest, input logic user);
        int  total;
        logic full;
        if (m_res.size() > 0 && (id != m_id || dest != m_dest)) model_flush();
        for (int i = 0; i < 4; i++) begin
            if (k[i]) m_res.push_back(d[8*i +: 8]);
        end
        m_id   = id;
        m_dest = dest;
        m_user = user;
        total  = m_res.size();
        full   = 1'b0;
        if (total >= 4) begin
            emit(4, l && (total == 4), id, dest, user);
            full = 1'b1;
        end
        if (l && (m_res.size() > 0 || !full)) emit(m_res.size(), 1'b1, id, dest, user);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [2:0] id, input logic dest, input logic user,
                             output int stalls);
        logic done;
        rx_tvalid = 1'b1;
        rx_tdata  = d;
        rx_tkeep  = k;
        rx_tlast  = l;
        rx_tid    = id;
        rx_tdest  = dest;
        rx_tuser  = user;
        stalls    = 0;
        done      = 1'b0;
        while (!done) begin
            @(negedge aclk);
            if (rx_tready) begin
                model_accept(d, k, l, id, dest, user);
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 500) begin
                    check("rx_accept_timeout", 64'(rx_tready), 64'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge aclk);
        #1;
        rx_tvalid = 1'b0;
    endtask

    always @(posedge aclk) begin
        if (rand_ready) begin
            #1;
            tx_tready = ($urandom_range(0, 3) != 0);
        end
    end

    logic        have_prev = 1'b0;
    logic [42:0] prev_snap;

    always @(negedge aclk) begin
        logic [42:0] snap;
        logic [31:0] mask;
        beat_t       b;
        #1;
        snap = {tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tid, tx_tdest, tx_tuser};
        if (areset || in_reset) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) check("stall_hold", 64'(snap), 64'(prev_snap));
            if (tx_tvalid && tx_tready) begin
                check("tkeep_thermometer", 64'(tx_tkeep & (tx_tkeep + 4'd1)), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    b = exp_q.pop_front();
                    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{tx_tkeep[i]}};
                    check("tx_tkeep", 64'(tx_tkeep), 64'(b.keep));
                    check("tx_tdata", 64'(tx_tdata & mask), 64'(b.data));
                    check("tx_tlast", 64'(tx_tlast), 64'(b.last));
                    check("tx_tid", 64'(tx_tid), 64'(b.id));
                    check("tx_tdest", 64'(tx_tdest), 64'(b.dest));
                    check("tx_tuser", 64'(tx_tuser), 64'(b.user));
                end
            end
            have_prev = tx_tvalid && !tx_tready;
            prev_snap = snap;
        end
    end

    initial begin
        int         stalls;
        int         cyc;
        logic [2:0] cur_id;

        areset    = 1'b1;
        in_reset  = 1'b1;
        rx_tvalid = 1'b0;
        rx_tdata  = '0;
        rx_tkeep  = '0;
        rx_tlast  = 1'b0;
        rx_tid    = '0;
        rx_tdest  = '0;
        rx_tuser  = '0;
        tx_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rx_tready_in_reset", 64'(rx_tready), 64'd0);
        check("reset_tvalid", 64'(tx_tvalid), 64'd0);
        check("reset_tkeep", 64'(tx_tkeep), 64'd0);
        check("reset_tlast", 64'(tx_tlast), 64'd0);
        check("reset_tdata", 64'(tx_tdata), 64'd0);
        check("reset_tid", 64'(tx_tid), 64'd0);
        areset   = 1'b0;
        in_reset = 1'b0;
        #1;
        check("rx_tready_after_reset", 64'(rx_tready), 64'd1);

        // Sparse packing across beats, then tlast with an overflowing remainder.
        send_beat(32'h77B2_55A1, 4'b0101, 1'b0, 3'd0, 1'b0, 1'b0, stalls);
        send_beat(32'hE5D4_C3FF, 4'b1110, 1'b0, 3'd0, 1'b0, 1'b1, stalls);
        send_beat(32'h1918_1716, 4'b1111, 1'b1, 3'd0, 1'b0, 1'b0, stalls);
        check("flush_state_rx_tready", 64'(rx_tready), 64'd0);
        @(posedge aclk);
        #1;
        check("rx_tready_after_flush", 64'(rx_tready), 64'd1);

        // Flow change with a 2-byte residue.
        send_beat(32'h9988_2B1A, 4'b0011, 1'b0, 3'd3, 1'b0, 1'b1, stalls);
        send_beat(32'h4D3C_2B1A, 4'b1111, 1'b1, 3'd5, 1'b0, 1'b0, stalls);
        check("id_flush_stall_cycles", 64'(stalls), 64'd1);

        // Idle timeout on a 3-byte residue.
        send_beat(32'h0063_6261, 4'b0111, 1'b0, 3'd5, 1'b0, 1'b1, stalls);
        model_flush();
        cyc = 0;
        while (!tx_tvalid && cyc < 30) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        check("timeout_latency", 64'(cyc), 64'd8);
        check("timeout_tkeep", 64'(tx_tkeep), 64'h7);

        // Reset with a residue and a stalled output beat.
        repeat (2) @(posedge aclk);
        #1;
        tx_tready = 1'b0;
        send_beat(32'h0033_2211, 4'b0111, 1'b0, 3'd5, 1'b0, 1'b0, stalls);
        send_beat(32'h7766_5544, 4'b1111, 1'b0, 3'd5, 1'b0, 1'b0, stalls);
        repeat (2) @(posedge aclk);
        #1;
        check("stalled_before_reset", 64'(tx_tvalid), 64'd1);
        in_reset = 1'b1;
        areset   = 1'b1;
        #1;
        check("rx_tready_mid_reset", 64'(rx_tready), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("post_reset_tvalid", 64'(tx_tvalid), 64'd0);
        check("post_reset_tkeep", 64'(tx_tkeep), 64'd0);
        check("post_reset_tlast", 64'(tx_tlast), 64'd0);
        exp_q.delete();
        m_res.delete();
        m_id     = 3'd0;
        m_dest   = 1'b0;
        m_user   = 1'b0;
        in_reset = 1'b0;
        tx_tready = 1'b1;
        send_beat(32'hA3A2_A1A0, 4'b1111, 1'b1, 3'd1, 1'b0, 1'b0, stalls);
        send_beat(32'h0000_00B0, 4'b0001, 1'b1, 3'd1, 1'b0, 1'b1, stalls);

        // Random tkeep/tlast/flow with random backpressure.
        rand_ready = 1'b1;
        cur_id     = 3'd1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l;
            int          gap;
            d   = $urandom();
            k   = 4'($urandom_range(0, 15));
            l   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) cur_id = cur_id ^ 3'd1;
            if (i == 199) begin
                k = 4'b1111;
                l = 1'b1;
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge aclk);
                #1;
            end
            send_beat(d, k, l, cur_id, 1'b0, 1'($urandom_range(0, 1)), stalls);
        end
        rand_ready = 1'b0;
        @(posedge aclk);
        #2;
        tx_tready = 1'b1;

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
